// File: rtl/fft_pkg.sv
// Shared FFT layer definitions: default widths, complex sample type and
// the rounding / saturation helpers used by every butterfly stage.
package fft_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int TWID_W_DEF = 16;
   localparam int WIDE_W     = 64;

   typedef struct packed {
      logic signed [DATA_W_DEF-1:0] re;
      logic signed [DATA_W_DEF-1:0] im;
   } cplx_t;

   // Round half up, then arithmetic shift right by sh bits.
   function automatic logic signed [WIDE_W-1:0] round_shr(input logic signed [WIDE_W-1:0] v,
                                                          input int sh);
      logic signed [WIDE_W-1:0] bias;
      if (sh <= 0) return v;
      bias = 64'sd1 <<< (sh - 1);
      return (v + bias) >>> sh;
   endfunction

   // Clamp to the signed range of a w-bit two's complement number.
   function automatic logic signed [WIDE_W-1:0] saturate(input logic signed [WIDE_W-1:0] v,
                                                         input int w);
      logic signed [WIDE_W-1:0] hi;
      logic signed [WIDE_W-1:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/fft_cmult.sv
// Registered complex multiply P = B*W with rounding back to DATA_W+1 bits.
// Also carries A, the write addresses and the valid/last tags alongside P.
module fft_cmult
   import fft_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int TWID_W    = TWID_W_DEF,
   parameter int ADDR_SIZE = 5
) (
   input  logic                        i_CLK,
   input  logic                        i_RST,
   input  logic                        i_valid,
   input  logic                        i_last,
   input  logic        [ADDR_SIZE-1:0] i_addr_A,
   input  logic        [ADDR_SIZE-1:0] i_addr_B,
   input  logic signed [DATA_W-1:0]    i_a_re,
   input  logic signed [DATA_W-1:0]    i_a_im,
   input  logic signed [DATA_W-1:0]    i_b_re,
   input  logic signed [DATA_W-1:0]    i_b_im,
   input  logic signed [TWID_W-1:0]    i_tw_re,
   input  logic signed [TWID_W-1:0]    i_tw_im,
   output logic                        vld_p1,
   output logic                        last_p1,
   output logic        [ADDR_SIZE-1:0] addr_A_p1,
   output logic        [ADDR_SIZE-1:0] addr_B_p1,
   output logic signed [DATA_W-1:0]    a_re_p1,
   output logic signed [DATA_W-1:0]    a_im_p1,
   output logic signed [DATA_W:0]      p_re_p1,
   output logic signed [DATA_W:0]      p_im_p1
);

   localparam int PW = DATA_W + TWID_W + 1;

   logic signed [PW-1:0] prod_re_p0;
   logic signed [PW-1:0] prod_im_p0;

   // Full-precision cross products; PW bits hold the worst-case sum exactly.
   always_comb begin
      prod_re_p0 = PW'(i_b_re) * PW'(i_tw_re) - PW'(i_b_im) * PW'(i_tw_im);
      prod_im_p0 = PW'(i_b_re) * PW'(i_tw_im) + PW'(i_b_im) * PW'(i_tw_re);
   end

   // ---- stage 1 boundary: control tags (reset so in-flight work is dropped)
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else begin
         vld_p1  <= i_valid;
         last_p1 <= i_valid & i_last;
      end
   end

   // Stage 1 datapath: rounded product, operand A and addresses.
   always_ff @(posedge i_CLK) begin
      addr_A_p1 <= i_addr_A;
      addr_B_p1 <= i_addr_B;
      a_re_p1   <= i_a_re;
      a_im_p1   <= i_a_im;
      p_re_p1   <= (DATA_W+1)'(round_shr(WIDE_W'(prod_re_p0), TWID_W - 1));
      p_im_p1   <= (DATA_W+1)'(round_shr(WIDE_W'(prod_im_p0), TWID_W - 1));
   end

endmodule

// File: rtl/fft_butterfly_writer.sv
// Write-back end of one FFT layer: radix-2 butterfly X = A + B*W, Y = A - B*W
// driven onto the sample memory write ports, with write count and layer-done.
module fft_butterfly_writer
   import fft_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int TWID_W    = TWID_W_DEF,
   parameter int ADDR_SIZE = 5,
   parameter int SCALE     = 1
) (
   input  logic                        i_CLK,
   input  logic                        i_RST,
   input  logic                        i_start,
   input  logic                        i_valid,
   input  logic                        i_last,
   input  logic        [ADDR_SIZE-1:0] i_addr_A,
   input  logic        [ADDR_SIZE-1:0] i_addr_B,
   input  logic signed [DATA_W-1:0]    i_data_A_re,
   input  logic signed [DATA_W-1:0]    i_data_A_im,
   input  logic signed [DATA_W-1:0]    i_data_B_re,
   input  logic signed [DATA_W-1:0]    i_data_B_im,
   input  logic signed [TWID_W-1:0]    i_tw_re,
   input  logic signed [TWID_W-1:0]    i_tw_im,
   output logic                        o_wren,
   output logic        [ADDR_SIZE-1:0] o_wraddr_A,
   output logic        [ADDR_SIZE-1:0] o_wraddr_B,
   output logic signed [DATA_W-1:0]    o_wrdata_A_re,
   output logic signed [DATA_W-1:0]    o_wrdata_A_im,
   output logic signed [DATA_W-1:0]    o_wrdata_B_re,
   output logic signed [DATA_W-1:0]    o_wrdata_B_im,
   output logic        [ADDR_SIZE-1:0] o_wr_count,
   output logic                        o_done
);

   localparam int SW = DATA_W + 2;

   logic                        vld_p1;
   logic                        last_p1;
   logic        [ADDR_SIZE-1:0] addr_A_p1;
   logic        [ADDR_SIZE-1:0] addr_B_p1;
   logic signed [DATA_W-1:0]    a_re_p1;
   logic signed [DATA_W-1:0]    a_im_p1;
   logic signed [DATA_W:0]      p_re_p1;
   logic signed [DATA_W:0]      p_im_p1;

   logic signed [SW-1:0] x_re_p1;
   logic signed [SW-1:0] x_im_p1;
   logic signed [SW-1:0] y_re_p1;
   logic signed [SW-1:0] y_im_p1;

   // Optional halving for per-layer scaling, then clamp to the sample range.
   function automatic logic signed [DATA_W-1:0] scale_sat(input logic signed [SW-1:0] v);
      logic signed [WIDE_W-1:0] t;
      t = WIDE_W'(v);
      if (SCALE != 0) t = round_shr(t, 1);
      t = saturate(t, DATA_W);
      return DATA_W'(t);
   endfunction

   fft_cmult #(
      .DATA_W   (DATA_W),
      .TWID_W   (TWID_W),
      .ADDR_SIZE(ADDR_SIZE)
   ) u_cmult (
      .i_CLK    (i_CLK),
      .i_RST    (i_RST),
      .i_valid  (i_valid),
      .i_last   (i_last),
      .i_addr_A (i_addr_A),
      .i_addr_B (i_addr_B),
      .i_a_re   (i_data_A_re),
      .i_a_im   (i_data_A_im),
      .i_b_re   (i_data_B_re),
      .i_b_im   (i_data_B_im),
      .i_tw_re  (i_tw_re),
      .i_tw_im  (i_tw_im),
      .vld_p1   (vld_p1),
      .last_p1  (last_p1),
      .addr_A_p1(addr_A_p1),
      .addr_B_p1(addr_B_p1),
      .a_re_p1  (a_re_p1),
      .a_im_p1  (a_im_p1),
      .p_re_p1  (p_re_p1),
      .p_im_p1  (p_im_p1)
   );

   // Butterfly add/subtract with two guard bits so nothing wraps before clamping.
   always_comb begin
      x_re_p1 = SW'(a_re_p1) + SW'(p_re_p1);
      x_im_p1 = SW'(a_im_p1) + SW'(p_im_p1);
      y_re_p1 = SW'(a_re_p1) - SW'(p_re_p1);
      y_im_p1 = SW'(a_im_p1) - SW'(p_im_p1);
   end

   // ---- stage 2 boundary: write port registers; data only updates on valid
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         o_wren        <= 1'b0;
         o_wraddr_A    <= '0;
         o_wraddr_B    <= '0;
         o_wrdata_A_re <= '0;
         o_wrdata_A_im <= '0;
         o_wrdata_B_re <= '0;
         o_wrdata_B_im <= '0;
      end else begin
         o_wren <= vld_p1;
         if (vld_p1) begin
            o_wraddr_A    <= addr_A_p1;
            o_wraddr_B    <= addr_B_p1;
            o_wrdata_A_re <= scale_sat(x_re_p1);
            o_wrdata_A_im <= scale_sat(x_im_p1);
            o_wrdata_B_re <= scale_sat(y_re_p1);
            o_wrdata_B_im <= scale_sat(y_im_p1);
         end
      end
   end

   // Count writes and flag layer completion in step with the write pulse;
   // a start on the same edge as a write keeps that write in the new count.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         o_wr_count <= '0;
         o_done     <= 1'b0;
      end else if (i_start) begin
         o_wr_count <= vld_p1 ? ADDR_SIZE'(1) : '0;
         o_done     <= 1'b0;
      end else begin
         if (vld_p1) o_wr_count <= o_wr_count + ADDR_SIZE'(1);
         if (vld_p1 && last_p1) o_done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fft_butterfly_writer.sv
// Directed bench for fft_butterfly_writer: one instance with scaling, one without.
module tb_fft_butterfly_writer;

   localparam int DW = 16;
   localparam int TW = 16;
   localparam int AW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst, start, valid, last;
   logic        [AW-1:0] addr_A, addr_B;
   logic signed [DW-1:0] a_re, a_im, b_re, b_im;
   logic signed [TW-1:0] w_re, w_im;

   logic                 s1_wren, s0_wren, s1_done, s0_done;
   logic        [AW-1:0] s1_wa, s1_wb, s0_wa, s0_wb, s1_cnt, s0_cnt;
   logic signed [DW-1:0] s1_xr, s1_xi, s1_yr, s1_yi;
   logic signed [DW-1:0] s0_xr, s0_xi, s0_yr, s0_yi;

   int n_cmp = 0;
   int n_err = 0;

   fft_butterfly_writer #(.DATA_W(DW), .TWID_W(TW), .ADDR_SIZE(AW), .SCALE(1)) dut_s1 (
      .i_CLK(clk), .i_RST(rst), .i_start(start), .i_valid(valid), .i_last(last),
      .i_addr_A(addr_A), .i_addr_B(addr_B),
      .i_data_A_re(a_re), .i_data_A_im(a_im), .i_data_B_re(b_re), .i_data_B_im(b_im),
      .i_tw_re(w_re), .i_tw_im(w_im),
      .o_wren(s1_wren), .o_wraddr_A(s1_wa), .o_wraddr_B(s1_wb),
      .o_wrdata_A_re(s1_xr), .o_wrdata_A_im(s1_xi), .o_wrdata_B_re(s1_yr), .o_wrdata_B_im(s1_yi),
      .o_wr_count(s1_cnt), .o_done(s1_done)
   );

   fft_butterfly_writer #(.DATA_W(DW), .TWID_W(TW), .ADDR_SIZE(AW), .SCALE(0)) dut_s0 (
      .i_CLK(clk), .i_RST(rst), .i_start(start), .i_valid(valid), .i_last(last),
      .i_addr_A(addr_A), .i_addr_B(addr_B),
      .i_data_A_re(a_re), .i_data_A_im(a_im), .i_data_B_re(b_re), .i_data_B_im(b_im),
      .i_tw_re(w_re), .i_tw_im(w_im),
      .o_wren(s0_wren), .o_wraddr_A(s0_wa), .o_wraddr_B(s0_wb),
      .o_wrdata_A_re(s0_xr), .o_wrdata_A_im(s0_xi), .o_wrdata_B_re(s0_yr), .o_wrdata_B_im(s0_yi),
      .o_wr_count(s0_cnt), .o_done(s0_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid = 1'b0;
      last  = 1'b0;
      start = 1'b0;
   endtask

   task automatic drive(input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                        input logic signed [DW-1:0] ar, input logic signed [DW-1:0] ai,
                        input logic signed [DW-1:0] br, input logic signed [DW-1:0] bi,
                        input logic signed [TW-1:0] wr, input logic signed [TW-1:0] wi,
                        input logic lst);
      valid = 1'b1; last = lst; addr_A = aa; addr_B = ab;
      a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle();
      addr_A = '0; addr_B = '0; a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
      tick(); tick();
      n_cmp++; if (s1_wren !== 1'b0 || s0_wren !== 1'b0) begin n_err++; $display("FAIL reset_wren got %b/%b want 0", s1_wren, s0_wren); end
      n_cmp++; if (s1_done !== 1'b0 || s0_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b/%b want 0", s1_done, s0_done); end
      n_cmp++; if (s1_cnt !== 5'd0 || s0_cnt !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d/%0d want 0", s1_cnt, s0_cnt); end
      n_cmp++; if ({s0_wa, s0_wb, s0_xr, s0_xi, s0_yr, s0_yi} !== '0) begin n_err++; $display("FAIL reset_outputs got %h %h %h %h %h %h want 0", s0_wa, s0_wb, s0_xr, s0_xi, s0_yr, s0_yi); end
      rst = 1'b0;
   endtask

   task automatic test_scale1();
      drive(5'd3, 5'd19, 16'h1000, 16'h0000, 16'h0800, 16'h0000, 16'h7FFF, 16'h0000, 1'b0);
      tick(); idle();
      n_cmp++; if (s1_wren !== 1'b0) begin n_err++; $display("FAIL scale1_early_wren got %b want 0", s1_wren); end
      tick();
      n_cmp++; if (s1_wren !== 1'b1) begin n_err++; $display("FAIL scale1_wren got %b want 1", s1_wren); end
      n_cmp++; if (s1_xr !== 16'h0C00 || s1_xi !== 16'h0000) begin n_err++; $display("FAIL scale1_X got %h,%h want 0c00,0000", s1_xr, s1_xi); end
      n_cmp++; if (s1_yr !== 16'h0400 || s1_yi !== 16'h0000) begin n_err++; $display("FAIL scale1_Y got %h,%h want 0400,0000", s1_yr, s1_yi); end
      n_cmp++; if (s1_wa !== 5'd3 || s1_wb !== 5'd19) begin n_err++; $display("FAIL scale1_addr got %0d,%0d want 3,19", s1_wa, s1_wb); end
      tick();
      n_cmp++; if (s1_wren !== 1'b0) begin n_err++; $display("FAIL scale1_single_pulse got %b want 0", s1_wren); end
   endtask

   task automatic test_imag_twiddle();
      drive(5'd5, 5'd21, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 16'h0000, 16'h8000, 1'b0);
      tick(); idle(); tick();
      n_cmp++; if (s0_xr !== 16'h0000 || s0_xi !== 16'hF800) begin n_err++; $display("FAIL imag_X got %h,%h want 0000,f800", s0_xr, s0_xi); end
      n_cmp++; if (s0_yr !== 16'h0000 || s0_yi !== 16'h0800) begin n_err++; $display("FAIL imag_Y got %h,%h want 0000,0800", s0_yr, s0_yi); end
   endtask

   task automatic test_saturation();
      drive(5'd7, 5'd23, 16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0);
      tick(); idle(); tick();
      n_cmp++; if (s0_xr !== 16'h7FFF) begin n_err++; $display("FAIL sat_Xre got %h want 7fff", s0_xr); end
      n_cmp++; if (s0_yr !== 16'h0001) begin n_err++; $display("FAIL sat_Yre got %h want 0001", s0_yr); end
      n_cmp++; if (s0_xi !== 16'h0000 || s0_yi !== 16'h0000) begin n_err++; $display("FAIL sat_im got %h,%h want 0,0", s0_xi, s0_yi); end
   endtask

   task automatic test_back_to_back();
      logic signed [DW-1:0] av;
      start = 1'b1; tick(); start = 1'b0;
      n_cmp++; if (s0_cnt !== 5'd0 || s0_done !== 1'b0) begin n_err++; $display("FAIL b2b_start got cnt=%0d done=%b want 0,0", s0_cnt, s0_done); end
      for (int i = 0; i < 4; i++) begin
         av = DW'(256 * (i + 1));
         drive(AW'(i), AW'(i + 16), av, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, (i == 3));
         tick();
         if (i > 0) begin
            n_cmp++; if (s0_wren !== 1'b1 || s0_xr !== DW'(256 * i) || s0_yr !== DW'(256 * i) || s0_wa !== AW'(i - 1))
               begin n_err++; $display("FAIL b2b_write%0d got wren=%b X=%h Y=%h addr=%0d want 1 %h %h %0d", i - 1, s0_wren, s0_xr, s0_yr, s0_wa, DW'(256 * i), DW'(256 * i), i - 1); end
            n_cmp++; if (s0_cnt !== AW'(i) || s0_done !== 1'b0) begin n_err++; $display("FAIL b2b_count%0d got cnt=%0d done=%b want %0d,0", i - 1, s0_cnt, s0_done, i); end
         end
      end
      idle(); tick();
      n_cmp++; if (s0_wren !== 1'b1 || s0_xr !== 16'h0400 || s0_wa !== 5'd3 || s0_wb !== 5'd19) begin n_err++; $display("FAIL b2b_write3 got wren=%b X=%h addr=%0d,%0d want 1 0400 3,19", s0_wren, s0_xr, s0_wa, s0_wb); end
      n_cmp++; if (s0_cnt !== 5'd4 || s0_done !== 1'b1) begin n_err++; $display("FAIL b2b_done got cnt=%0d done=%b want 4,1", s0_cnt, s0_done); end
      n_cmp++; if (s1_cnt !== 5'd4 || s1_done !== 1'b1) begin n_err++; $display("FAIL b2b_done_s1 got cnt=%0d done=%b want 4,1", s1_cnt, s1_done); end
      tick();
      n_cmp++; if (s0_wren !== 1'b0 || s0_cnt !== 5'd4 || s0_done !== 1'b1) begin n_err++; $display("FAIL b2b_bubble got wren=%b cnt=%0d done=%b want 0,4,1", s0_wren, s0_cnt, s0_done); end
      start = 1'b1; tick(); start = 1'b0;
      n_cmp++; if (s0_cnt !== 5'd0 || s0_done !== 1'b0) begin n_err++; $display("FAIL b2b_restart got cnt=%0d done=%b want 0,0", s0_cnt, s0_done); end
   endtask

   task automatic test_last_without_valid();
      start = 1'b1; tick(); start = 1'b0;
      valid = 1'b0; last = 1'b1; tick(); idle(); tick(); tick();
      n_cmp++; if (s0_done !== 1'b0 || s0_wren !== 1'b0 || s0_cnt !== 5'd0) begin n_err++; $display("FAIL last_no_valid got done=%b wren=%b cnt=%0d want 0,0,0", s0_done, s0_wren, s0_cnt); end
   endtask

   task automatic test_reset_mid();
      int pulses;
      pulses = 0;
      start = 1'b1; tick(); start = 1'b0;
      drive(5'd9, 5'd25, 16'h1234, 16'h0011, 16'h0100, 16'h0000, 16'h7FFF, 16'h0000, 1'b0);
      tick();
      drive(5'd10, 5'd26, 16'h2345, 16'h0022, 16'h0100, 16'h0000, 16'h7FFF, 16'h0000, 1'b1);
      rst = 1'b1;
      tick();
      if (s0_wren || s1_wren) pulses++;
      idle(); rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (s0_wren || s1_wren) pulses++;
      end
      n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL rstmid_pulses got %0d want 0", pulses); end
      n_cmp++; if (s0_done !== 1'b0 || s1_done !== 1'b0 || s0_cnt !== 5'd0) begin n_err++; $display("FAIL rstmid_state got done=%b/%b cnt=%0d want 0,0,0", s0_done, s1_done, s0_cnt); end
      n_cmp++; if ({s0_wa, s0_wb, s0_xr, s0_xi, s0_yr, s0_yi} !== '0) begin n_err++; $display("FAIL rstmid_outputs got %h %h %h %h %h %h want 0", s0_wa, s0_wb, s0_xr, s0_xi, s0_yr, s0_yi); end
   endtask

   initial begin
      test_reset();
      test_scale1();
      test_imag_twiddle();
      test_saturation();
      test_back_to_back();
      test_last_without_valid();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
